// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard for RAW hazard detection.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    output logic                hazard,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                flush,
    output logic [AW:0]         pending_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wr_hit;
    logic             issue_hit;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [AW:0]      flush_cnt;

    assign wr_hit    = wr_en && (wr_addr != '0);
    assign issue_hit = issue_en && (issue_addr != '0);

    // Per-register priority: a new producer beats flush, which beats writeback.
    always_comb begin
        busy_next = busy;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (issue_hit && issue_addr == AW'(r)) begin
                busy_next[r] = 1'b1;
            end else if (flush) begin
                busy_next[r] = 1'b0;
            end else if (wr_hit && wr_addr == AW'(r)) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_comb begin
        flush_cnt = '0;
        for (int r = 1; r < NREGS; r++) begin
            flush_cnt = flush_cnt + (AW+1)'(busy_next[r]);
        end
    end

    // Incremental count; a write that clears the same register being reissued is not a decrement.
    always_comb begin
        cnt_inc = issue_hit && !busy[issue_addr];
        cnt_dec = wr_hit && busy[wr_addr] && !(issue_hit && issue_addr == wr_addr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                pending_cnt <= flush_cnt;
            end else begin
                pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            if (rd_addr[p*AW +: AW] != '0) begin
                rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
                rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wr_hit && rd_addr[p*AW +: AW] == wr_addr) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                    rd_busy[p]              = issue_en && (issue_addr == wr_addr);
                end
`endif
            end
        end
    end

    assign hazard = |rd_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                hazard;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                flush;
    logic [AW:0]         pending_cnt;

    int checks;
    int errors;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .hazard      (hazard),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                  input logic ie, input logic [AW-1:0] ia, input logic fl);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        flush      = fl;
    endtask

    task automatic set_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rd_addr = '0;
        apply_stimulus(1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 1'b0);
        @(negedge clock);
        step();
        reset = 1'b0;
        idle();

        // 1: everything clear after reset
        for (int a = 0; a < NREGS; a++) begin
            set_read(AW'(a), AW'(NREGS - 1 - a));
            check_output($sformatf("reset_data_%0d", a), 64'(rd_data), 64'h0);
            check_output($sformatf("reset_busy_%0d", a), 64'({hazard, rd_busy}), 64'h0);
        end
        check_output("reset_pending", 64'(pending_cnt), 64'd0);

        // 2: basic write, x0 discard
        apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
        step();
        idle();
        set_read(5'd5, 5'd0);
        check_output("x5_p0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        check_output("x0_p1", 64'(rd_data[63:32]), 64'h0);
        apply_stimulus(1'b1, 5'd0, 32'h1, 1'b0, '0, 1'b0);
        step();
        idle();
        set_read(5'd0, 5'd5);
        check_output("x0_after_write", 64'(rd_data[31:0]), 64'h0);
        check_output("x5_p1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);

        // 3: issue then writeback
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
        step();
        idle();
        set_read(5'd7, 5'd0);
        check_output("x7_busy", 64'(rd_busy), 64'b01);
        check_output("x7_hazard", 64'(hazard), 64'd1);
        check_output("x7_pending", 64'(pending_cnt), 64'd1);
        apply_stimulus(1'b1, 5'd7, 32'h42, 1'b0, '0, 1'b0);
        step();
        idle();
        set_read(5'd7, 5'd7);
        check_output("x7_wb_busy", 64'({hazard, rd_busy}), 64'b000);
        check_output("x7_wb_pending", 64'(pending_cnt), 64'd0);
        check_output("x7_wb_data", 64'(rd_data), {32'h42, 32'h42});

        // 4: same-cycle issue and writeback: issue wins
        apply_stimulus(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 1'b0);
        step();
        idle();
        set_read(5'd0, 5'd9);
        check_output("x9_busy", 64'(rd_busy), 64'b10);
        check_output("x9_hazard", 64'(hazard), 64'd1);
        check_output("x9_data", 64'(rd_data[63:32]), 64'h11);
        check_output("x9_pending", 64'(pending_cnt), 64'd1);

        // 5: several issues, then flush alongside a new issue
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd1, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd2, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
        step();
        idle();
        check_output("four_pending", 64'(pending_cnt), 64'd4);
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b1);
        step();
        idle();
        check_output("flush_pending", 64'(pending_cnt), 64'd1);
        set_read(5'd1, 5'd4);
        check_output("flush_x1_x4_busy", 64'(rd_busy), 64'b10);
        set_read(5'd9, 5'd3);
        check_output("flush_x9_x3_busy", 64'({hazard, rd_busy}), 64'b000);
        check_output("flush_keeps_data", 64'(rd_data[31:0]), 64'h11);

        // Reissue of a busy register and issue to x0 leave the count alone
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd0, 1'b0);
        step();
        idle();
        check_output("reissue_pending", 64'(pending_cnt), 64'd1);
        set_read(5'd0, 5'd4);
        check_output("x0_never_busy", 64'(rd_busy), 64'b10);

        // Writeback of a different register in the same cycle as an issue
        apply_stimulus(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 1'b0);
        step();
        idle();
        check_output("swap_pending", 64'(pending_cnt), 64'd1);
        set_read(5'd4, 5'd6);
        check_output("swap_busy", 64'(rd_busy), 64'b10);
        check_output("swap_data", 64'(rd_data[31:0]), 64'h4444);

        // 6: same-cycle read of a register being written
        apply_stimulus(1'b1, 5'd12, 32'hA5A5_A5A5, 1'b0, '0, 1'b0);
        set_read(5'd12, 5'd12);
        check_output("bypass_data", 64'(rd_data[31:0]), BYPASS ? 64'hA5A5_A5A5 : 64'h0);
        check_output("bypass_p1_equal", 64'(rd_data[63:32]), BYPASS ? 64'hA5A5_A5A5 : 64'h0);
        check_output("bypass_busy", 64'(rd_busy), 64'b00);
        step();
        idle();
        set_read(5'd12, 5'd0);
        check_output("x12_after", 64'(rd_data[31:0]), 64'hA5A5_A5A5);
        apply_stimulus(1'b1, 5'd12, 32'h5A5A_5A5A, 1'b1, 5'd12, 1'b0);
        set_read(5'd12, 5'd0);
        check_output("bypass_issue_data", 64'(rd_data[31:0]), BYPASS ? 64'h5A5A_5A5A : 64'hA5A5_A5A5);
        check_output("bypass_issue_busy", 64'(rd_busy), BYPASS ? 64'b01 : 64'b00);
        step();
        idle();
        set_read(5'd12, 5'd6);
        check_output("x12_issue_busy", 64'(rd_busy), 64'b11);
        check_output("x12_issue_pending", 64'(pending_cnt), 64'd2);

        // Reset mid-stream overrides pending write/issue/flush
        reset = 1'b1;
        apply_stimulus(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd8, 1'b1);
        step();
        reset = 1'b0;
        idle();
        set_read(5'd5, 5'd12);
        check_output("midreset_data", 64'(rd_data), 64'h0);
        check_output("midreset_busy", 64'({hazard, rd_busy}), 64'b000);
        set_read(5'd8, 5'd9);
        check_output("midreset_busy2", 64'({hazard, rd_busy}), 64'b000);
        check_output("midreset_pending", 64'(pending_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
